// File: rtl/uart_rx_capture_if.sv
// Show-ahead byte stream from the UART receiver FIFO: head data, valid, ready and occupancy.
interface uart_rx_capture_if #(
    parameter int FIFO_DEPTH = 8
);
    logic [7:0]                    data;
    logic                          valid;
    logic                          ready;
    logic [$clog2(FIFO_DEPTH):0]   count;

    modport master (output data, output valid, output count, input ready);
    modport slave  (input data, input valid, input count, output ready);
endinterface

// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver that deframes the SoC uart_tx stream into a small show-ahead byte FIFO.
// Framing errors and FIFO overflow are reported as single-cycle pulses.
module uart_rx_capture #(
    parameter int CLKS_PER_BIT = 32,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_i,
    input  logic              rx_en_i,
    uart_rx_capture_if.master bus,
    output logic              frame_err_o,
    output logic              overflow_o
);
    localparam int CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int COUNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    logic [1:0]       sync_q;
    logic [1:0]       primed;
    logic             rx_prev;
    logic             rx_s;
    logic             fall;
    logic [2:0]       state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             sample;
    logic             push;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [COUNT_W-1:0] count;
    logic               full;
    logic               pop;
    logic               do_write;

    assign rx_s   = sync_q[1];
    assign fall   = rx_prev & ~rx_s;
    assign sample = (bit_cnt == '0);
    assign push   = rx_en_i && (state == STOP) && sample && rx_s;

    // rx_prev only tracks real samples once the synchronizer has flushed its reset value,
    // so a line already low when reset releases does not look like a start edge.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            primed  <= 2'b00;
            rx_prev <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            primed  <= {primed[0], 1'b1};
            rx_prev <= rx_s & primed[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            frame_err_o <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            if (!rx_en_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (fall) begin
                        bit_cnt <= HALF_LOAD;
                        state   <= START;
                    end
                    START: if (sample) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            bit_cnt <= FULL_LOAD;
                            bit_idx <= '0;
                            state   <= DATA;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                    DATA: if (sample) begin
                        shift[bit_idx] <= rx_s;
                        bit_cnt        <= FULL_LOAD;
                        if (bit_idx == 3'd7) state <= STOP;
                        else                 bit_idx <= bit_idx + 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                    STOP: if (sample) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            frame_err_o <= 1'b1;
                            state       <= BREAK;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                    // A held-low line parks here so it yields a single framing error.
                    BREAK: if (rx_s) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign full     = (count == COUNT_W'(FIFO_DEPTH));
    assign pop      = (count != '0) && bus.ready;
    assign do_write = push && (!full || pop);

    // NOTE: the storage array has no reset; only pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            overflow_o <= push && full && !pop;
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (pop)      rd_ptr <= rd_ptr + 1'b1;
            case ({do_write, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head byte is forced to zero while empty so outputs read 0 out of reset.
    assign bus.data  = (count != '0) ? mem[rd_ptr] : 8'h00;
    assign bus.valid = (count != '0);
    assign bus.count = count;
endmodule
